exec_unit: RTL and testbench

- Execute stage of the single-issue ARM-subset processor: PC incrementers (PC+4, PC+8), immediate extender, operand muxes and 32-bit ALU with NZCV flags.
- Combinational results feed next-PC and result-select logic in the same cycle.
- Result and flags are also held in an enable-gated output register, giving a one-cycle-latency copy for the flag/condition logic.

---
 rtl/exec_pkg.sv | 37 +++
 rtl/exec_alu.sv | 69 ++++++
 rtl/exec_unit.sv | 84 ++++++++
 tb/tb_exec_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: ALU opcodes, extender
// modes, NZCV flag bit positions and the ARM rotated-immediate helper.
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100,
        ALU_MOV = 3'b101,
        ALU_BIC = 3'b110,
        ALU_RSB = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_8    = 2'b00,
        IMM_12   = 2'b01,
        IMM_BR   = 2'b10,
        IMM_NONE = 2'b11
    } imm_src_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Zero-extended imm8 rotated right by 2*rot; duplicating the word turns
    // the rotate into a plain right shift.
    function automatic logic [31:0] rot_imm(logic [7:0] imm8, logic [3:0] rot);
        logic [63:0] dbl;
        dbl = {24'b0, imm8, 24'b0, imm8};
        dbl = dbl >> {rot, 1'b0};
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Purely combinational 32-bit ALU with NZCV flags.
// ADD/SUB/RSB share one adder: x + y + cin, with operands inverted as needed.
module exec_alu
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        alu_control,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    logic [DATA_W-1:0] add_x;
    logic [DATA_W-1:0] add_y;
    logic              add_cin;
    logic [DATA_W:0]   sum;
    logic              arith;

    // Select adder operands for the effective addition of the arithmetic ops.
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
        arith   = 1'b0;
        case (alu_op_e'(alu_control))
            ALU_ADD: begin
                arith = 1'b1;
            end
            ALU_SUB: begin
                add_y   = ~b;
                add_cin = 1'b1;
                arith   = 1'b1;
            end
            ALU_RSB: begin
                add_x   = b;
                add_y   = ~a;
                add_cin = 1'b1;
                arith   = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};

    // Result mux and flag generation; logic ops and MOV clear C and V.
    always_comb begin
        result = sum[DATA_W-1:0];
        case (alu_op_e'(alu_control))
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            ALU_EOR: result = a ^ b;
            ALU_MOV: result = b;
            ALU_BIC: result = a & ~b;
            default: result = sum[DATA_W-1:0];
        endcase
        flags         = 4'b0000;
        flags[FLAG_N] = result[DATA_W-1];
        flags[FLAG_Z] = (result == '0);
        if (arith) begin
            flags[FLAG_C] = sum[DATA_W];
            flags[FLAG_V] = (add_x[DATA_W-1] == add_y[DATA_W-1]) &&
                            (sum[DATA_W-1] != add_x[DATA_W-1]);
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: PC incrementers, immediate extender, operand muxes, ALU and
// an enable-gated result/flag register.
// Optional: define EXEC_IMM_ROT_EN to make imm_src=00 the ARM rotated
// immediate (imm8 rotated right by 2*instr[11:8]).
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned PC_STEP = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] pc,
    input  logic [23:0]       instr,
    input  logic [1:0]        imm_src,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic              srca_sel,
    input  logic              alu_src,
    input  logic [2:0]        alu_control,
    output logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] pc_plus8,
    output logic [DATA_W-1:0] ext_imm,
    output logic [DATA_W-1:0] alu_result,
    output logic [3:0]        alu_flags,
    output logic [DATA_W-1:0] alu_result_q,
    output logic [3:0]        alu_flags_q
);

    localparam logic [DATA_W-1:0] STEP1 = DATA_W'(PC_STEP);
    localparam logic [DATA_W-1:0] STEP2 = DATA_W'(2 * PC_STEP);

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;

    // PC incrementers wrap modulo 2^32.
    assign pc_plus4 = pc + STEP1;
    assign pc_plus8 = pc + STEP2;

    // Immediate extender.
    always_comb begin
        ext_imm = '0;
        case (imm_src_e'(imm_src))
            IMM_8: begin
`ifdef EXEC_IMM_ROT_EN
                ext_imm = rot_imm(instr[7:0], instr[11:8]);
`else
                ext_imm = {24'b0, instr[7:0]};
`endif
            end
            IMM_12:   ext_imm = {20'b0, instr[11:0]};
            IMM_BR:   ext_imm = {{6{instr[23]}}, instr[23:0], 2'b00};
            IMM_NONE: ext_imm = '0;
            default:  ext_imm = '0;
        endcase
    end

    // Operand selection.
    assign src_a = srca_sel ? pc_plus8 : rd1;
    assign src_b = alu_src ? ext_imm : rd2;

    exec_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a          (src_a),
        .b          (src_b),
        .alu_control(alu_control),
        .result     (alu_result),
        .flags      (alu_flags)
    );

    // One-cycle copy of result and flags; reset wins over enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q <= '0;
            alu_flags_q  <= 4'b0000;
        end else if (en) begin
            alu_result_q <= alu_result;
            alu_flags_q  <= alu_flags;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit.
module tb_exec_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] pc;
    logic [23:0] instr;
    logic [1:0]  imm_src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        srca_sel;
    logic        alu_src;
    logic [2:0]  alu_control;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic [31:0] ext_imm;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [31:0] alu_result_q;
    logic [3:0]  alu_flags_q;

    int n_checks;
    int n_fails;

    exec_unit u_dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pc          (pc),
        .instr       (instr),
        .imm_src     (imm_src),
        .rd1         (rd1),
        .rd2         (rd2),
        .srca_sel    (srca_sel),
        .alu_src     (alu_src),
        .alu_control (alu_control),
        .pc_plus4    (pc_plus4),
        .pc_plus8    (pc_plus8),
        .ext_imm     (ext_imm),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .alu_result_q(alu_result_q),
        .alu_flags_q (alu_flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Apply ALU operands (register sources) and settle.
    task automatic alu_rr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        srca_sel    = 1'b0;
        alu_src     = 1'b0;
        alu_control = op;
        rd1         = a;
        rd2         = b;
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        reset       = 1'b1;
        en          = 1'b0;
        pc          = 32'h0;
        instr       = 24'h0;
        imm_src     = 2'b11;
        rd1         = 32'h0;
        rd2         = 32'h0;
        srca_sel    = 1'b0;
        alu_src     = 1'b0;
        alu_control = 3'b000;
        #2;
        check_eq("reset_result_q", alu_result_q, 32'h0);
        check_eq("reset_flags_q", {28'h0, alu_flags_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // PC incrementers
        pc = 32'h0000_0100; #1;
        check_eq("pc4_100", pc_plus4, 32'h0000_0104);
        check_eq("pc8_100", pc_plus8, 32'h0000_0108);
        pc = 32'hFFFF_FFFC; #1;
        check_eq("pc4_wrap", pc_plus4, 32'h0000_0000);
        check_eq("pc8_wrap", pc_plus8, 32'h0000_0004);

        // Extender
        imm_src = 2'b10; instr = 24'hFFFFFE; #1;
        check_eq("ext_br_neg", ext_imm, 32'hFFFF_FFF8);
        instr = 24'h000003; #1;
        check_eq("ext_br_pos", ext_imm, 32'h0000_000C);
        imm_src = 2'b01; instr = 24'h000ABC; #1;
        check_eq("ext_imm12", ext_imm, 32'h0000_0ABC);
        imm_src = 2'b00; instr = 24'h0002FF; #1;
`ifdef EXEC_IMM_ROT_EN
        check_eq("ext_imm8_rot", ext_imm, 32'hF000_000F);
`else
        check_eq("ext_imm8", ext_imm, 32'h0000_00FF);
`endif
        instr = 24'h0000A5; #1;
        check_eq("ext_imm8_rot0", ext_imm, 32'h0000_00A5);
        imm_src = 2'b11; instr = 24'hFFFFFF; #1;
        check_eq("ext_none", ext_imm, 32'h0000_0000);

        // Arithmetic and flags
        alu_rr(3'b001, 32'd5, 32'd5);
        check_eq("sub_eq_res", alu_result, 32'h0);
        check_eq("sub_eq_flg", {28'h0, alu_flags}, 32'h6);
        alu_rr(3'b000, 32'h7FFF_FFFF, 32'h1);
        check_eq("add_ovf_res", alu_result, 32'h8000_0000);
        check_eq("add_ovf_flg", {28'h0, alu_flags}, 32'h9);
        alu_rr(3'b000, 32'hFFFF_FFFF, 32'h1);
        check_eq("add_cry_res", alu_result, 32'h0);
        check_eq("add_cry_flg", {28'h0, alu_flags}, 32'h6);
        alu_rr(3'b001, 32'd3, 32'd10);
        check_eq("sub_brw_res", alu_result, 32'hFFFF_FFF9);
        check_eq("sub_brw_flg", {28'h0, alu_flags}, 32'h8);
        alu_rr(3'b001, 32'h8000_0000, 32'h1);
        check_eq("sub_ovf_res", alu_result, 32'h7FFF_FFFF);
        check_eq("sub_ovf_flg", {28'h0, alu_flags}, 32'h3);
        alu_rr(3'b111, 32'd3, 32'd10);
        check_eq("rsb_res", alu_result, 32'h0000_0007);
        check_eq("rsb_flg", {28'h0, alu_flags}, 32'h2);

        // Logic ops
        alu_rr(3'b010, 32'h0000_F0F0, 32'h0000_FF00);
        check_eq("and_res", alu_result, 32'h0000_F000);
        check_eq("and_flg", {28'h0, alu_flags}, 32'h0);
        alu_rr(3'b011, 32'h0000_00F0, 32'h0000_000F);
        check_eq("orr_res", alu_result, 32'h0000_00FF);
        alu_rr(3'b100, 32'h0000_00FF, 32'h0000_000F);
        check_eq("eor_res", alu_result, 32'h0000_00F0);
        alu_rr(3'b110, 32'h0000_00FF, 32'h0000_000F);
        check_eq("bic_res", alu_result, 32'h0000_00F0);
        check_eq("bic_flg", {28'h0, alu_flags}, 32'h0);
        alu_rr(3'b110, 32'h0000_000F, 32'h0000_000F);
        check_eq("bic_zero_flg", {28'h0, alu_flags}, 32'h4);

        // MOV from immediate
        alu_rr(3'b101, 32'h1234_5678, 32'h9999_9999);
        alu_src = 1'b1; imm_src = 2'b01; instr = 24'h000ABC; #1;
        check_eq("mov_imm_res", alu_result, 32'h0000_0ABC);
        check_eq("mov_imm_flg", {28'h0, alu_flags}, 32'h0);

        // Branch target: PC+8 + (imm24 << 2)
        srca_sel = 1'b1; alu_src = 1'b1; imm_src = 2'b10; instr = 24'h000002;
        pc = 32'h0000_0020; alu_control = 3'b000; #1;
        check_eq("branch_tgt", alu_result, 32'h0000_0030);

        // Register stage: capture, then hold for 3 edges with changing inputs
        @(negedge clk);
        alu_rr(3'b000, 32'h11, 32'h22);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        check_eq("cap_res_q", alu_result_q, 32'h33);
        check_eq("cap_flg_q", {28'h0, alu_flags_q}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            alu_rr(3'b001, 32'd5 + 32'(i), 32'd5);
            @(posedge clk); #1;
            check_eq("hold_res_q", alu_result_q, 32'h33);
        end

        // Capture a flagged result, then reset mid-hold
        @(negedge clk);
        alu_rr(3'b000, 32'h7FFF_FFFF, 32'h1);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        check_eq("cap2_res_q", alu_result_q, 32'h8000_0000);
        check_eq("cap2_flg_q", {28'h0, alu_flags_q}, 32'h9);
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_res_q", alu_result_q, 32'h0);
        check_eq("rst_mid_flg_q", {28'h0, alu_flags_q}, 32'h0);

        // Reset has priority over en
        en = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_prio_res_q", alu_result_q, 32'h0);

        // First enabled edge after reset release captures
        @(negedge clk);
        reset = 1'b0;
        alu_rr(3'b001, 32'd5, 32'd5);
        @(posedge clk); #1;
        check_eq("post_rst_res_q", alu_result_q, 32'h0);
        check_eq("post_rst_flg_q", {28'h0, alu_flags_q}, 32'h6);
        @(negedge clk);
        alu_rr(3'b011, 32'hA000_0000, 32'h0000_0005);
        @(posedge clk); #1;
        check_eq("post_rst2_res_q", alu_result_q, 32'hA000_0005);
        check_eq("post_rst2_flg_q", {28'h0, alu_flags_q}, 32'h8);
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
